des_decryption_iterative: RTL and testbench
===========================================

DES_DECRYPTION_ITERATIVE -- requirements
Module: des_decryption_iterative

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 start  in  1  leaves INIT for READY; ignored in every other state.
REQ-005 pause  in  1  freezes all internal state while high.
REQ-006 restart_block  in  1  returns the block to INIT.
REQ-007 input_valid  in  1  ciphertext and round_keys are valid.
REQ-008 input_ready  out  1  block can accept a ciphertext this cycle.
REQ-009 ciphertext  in  [1:64]  block to decrypt, in DES bit order (bit 1 = MSB).
REQ-010 round_keys  in  [1:768]  K1..K16 in encryption order, 48 bits each, with K1 at [1:48]; must be held stable from acceptance to DONE.
REQ-011 output_ack  in  1  consumer has taken the result.
REQ-012 output_valid  out  1  result is valid and held.
REQ-013 result  out  [1:64]  decrypted plaintext.

Function
REQ-014 States SHALL be INIT, READY, ROUND and DONE.
REQ-015 INIT: outputs idle; start=1 moves to READY.
REQ-016 READY: input_ready=1 (combinational); input_valid=1 is an accept; on accept, L/R are loaded from IP(ciphertext), the round counter is set to 0 and the block moves to ROUND.
REQ-017 ROUND: each cycle performs one Feistel round, L' = R and R' = L xor f(R, K(16-cnt)); counter 0 uses K16 = round_keys[721:768] and counter 15 uses K1 = round_keys[1:48].
REQ-018 At the edge completing counter 15: result <= IP^-1({R16', L16'}) (final swap), the counter clears and the block moves to DONE.
REQ-019 Latency SHALL be exactly 16 rising edges from the accept edge to output_valid high, with no pause.
REQ-020 DONE: output_valid=1 and result held; output_ack=1 moves to READY; no new accept is possible in the same cycle as the ack.
REQ-021 pause=1 (any state): state, counter, L/R and result SHALL be frozen; input_ready forced to 0; output_ack and input_valid ignored; output_valid keeps its value.
REQ-022 restart_block=1: next state INIT, counter 0, output_valid 0; this overrides pause and any in-flight decryption; result is not cleared.
REQ-023 Priority SHALL be rst > restart_block > pause > normal operation.
REQ-024 The counter is 4 bits; wrap from 15 to 0 only on the ROUND-to-DONE transition.

Reset
REQ-025 On rst: state INIT, counter 0, L/R 0, result 64'h0, output_valid 0, input_ready 0.
REQ-026 Reset asserted mid-ROUND SHALL abandon the operation with no output_valid pulse.

Structure
REQ-027 The shared DES package SHALL hold the state encodings and the width constants: block 64, half 32, subkey 48, key bus 768, round count 16.
REQ-028 The existing ip_permutation and ip_inverse_permutation primitives SHALL be reused.
REQ-029 One new combinational sub-module, des_round_comb (E-expansion, key xor, S-boxes, P), SHALL implement a single round; the subkey SHALL be selected by an indexed part-select on the counter.

Verification
REQ-030 Round keys from key 133457799BBCDFF1, ciphertext 85E813540F0AB405 accepted at edge 0 -> output_valid at edge 16, result 0123456789ABCDEF.
REQ-031 Same vector with pause high for 5 cycles during counter 7 -> output_valid at edge 21, same result, input_ready 0 while paused.
REQ-032 restart_block pulsed at counter 8 -> output_valid never rises, state INIT, input_ready 0 until start.
REQ-033 output_ack held low for 10 cycles in DONE -> result and output_valid stable; ack -> input_ready 1 on the next cycle; a second block decrypts correctly.
REQ-034 rst asserted mid-ROUND -> all outputs at reset values the next cycle; start plus a new accept -> correct result 16 edges later.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES definitions: FSM encoding, width constants and the
// standard permutation / substitution tables (1-based DES numbering).
package des_pkg;

  localparam int BLOCK_W  = 64;
  localparam int HALF_W   = 32;
  localparam int SUBKEY_W = 48;
  localparam int KEYBUS_W = 768;
  localparam int ROUNDS   = 16;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_READY = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Initial permutation: output bit n takes input bit IP_T[n-1].
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int IPINV_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // S-boxes, row-major: entry index = row*16 + col.
  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
  };

endpackage

// File: rtl/des_round_comb.sv
// One combinational Feistel round: l_next = r, r_next = l ^ f(r, subkey).
// Ports: l, r halves in; subkey 48b; l_next, r_next halves out.
module des_round_comb
  import des_pkg::*;
(
  input  logic [HALF_W-1:0]   l,
  input  logic [HALF_W-1:0]   r,
  input  logic [SUBKEY_W-1:0] subkey,
  output logic [HALF_W-1:0]   l_next,
  output logic [HALF_W-1:0]   r_next
);

  logic [SUBKEY_W-1:0] e;
  logic [SUBKEY_W-1:0] x;
  logic [HALF_W-1:0]   s;
  logic [HALF_W-1:0]   f;

  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_e
    assign e[SUBKEY_W-1-i] = r[HALF_W-E_T[i]];
  end

  assign x = e ^ subkey;

  // Row is the outer bit pair (b1,b6), column the inner four bits.
  for (genvar b = 0; b < 8; b++) begin : g_s
    logic [5:0] six;
    assign six = x[SUBKEY_W-1-6*b -: 6];
    assign s[HALF_W-1-4*b -: 4] =
      4'(SBOX[b][{six[5], six[0], six[4:1]}]);
  end

  for (genvar i = 0; i < HALF_W; i++) begin : g_p
    assign f[HALF_W-1-i] = s[HALF_W-P_T[i]];
  end

  assign l_next = r;
  assign r_next = l ^ f;

endmodule

// File: rtl/ip_inverse_permutation.sv
// DES final permutation IP^-1 (wiring only).
// din/dout: 64-bit blocks, DES bit 1 is vector bit 63.
module ip_inverse_permutation
  import des_pkg::*;
(
  input  logic [BLOCK_W-1:0] din,
  output logic [BLOCK_W-1:0] dout
);

  for (genvar i = 0; i < BLOCK_W; i++) begin : g_bit
    assign dout[BLOCK_W-1-i] = din[BLOCK_W-IPINV_T[i]];
  end

endmodule

// File: rtl/ip_permutation.sv
// DES initial permutation (wiring only).
// din/dout: 64-bit blocks, DES bit 1 is vector bit 63.
module ip_permutation
  import des_pkg::*;
(
  input  logic [BLOCK_W-1:0] din,
  output logic [BLOCK_W-1:0] dout
);

  for (genvar i = 0; i < BLOCK_W; i++) begin : g_bit
    assign dout[BLOCK_W-1-i] = din[BLOCK_W-IP_T[i]];
  end

endmodule

// File: rtl/des_decryption_iterative.sv
// Iterative DES decryption, one round per clock, INIT/READY/ROUND/DONE.
// Ports: clk, rst (sync, high), start, pause, restart_block,
//   input_valid/input_ready + ciphertext + round_keys (K1 in the top
//   48 bits), output_valid/output_ack + result. DES bit 1 = vector MSB.
module des_decryption_iterative
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                pause,
  input  logic                restart_block,
  input  logic                input_valid,
  output logic                input_ready,
  input  logic [BLOCK_W-1:0]  ciphertext,
  input  logic [KEYBUS_W-1:0] round_keys,
  input  logic                output_ack,
  output logic                output_valid,
  output logic [BLOCK_W-1:0]  result
);

  state_t state;
  state_t state_n;

  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_n;
  logic [HALF_W-1:0]   l;
  logic [HALF_W-1:0]   r;
  logic [HALF_W-1:0]   l_n;
  logic [HALF_W-1:0]   r_n;
  logic [HALF_W-1:0]   rnd_l;
  logic [HALF_W-1:0]   rnd_r;
  logic [BLOCK_W-1:0]  result_n;
  logic [BLOCK_W-1:0]  ip_out;
  logic [BLOCK_W-1:0]  fp_out;
  logic [9:0]          key_base;
  logic [SUBKEY_W-1:0] subkey;
  logic                last_round;

  // Decryption walks the keys backwards: cnt 0 -> K16 (lowest 48 bits).
  assign key_base = {6'd0, cnt} * 10'd48;
  assign subkey   = round_keys[key_base +: SUBKEY_W];

  ip_permutation u_ip (
    .din  (ciphertext),
    .dout (ip_out)
  );

  des_round_comb u_round (
    .l      (l),
    .r      (r),
    .subkey (subkey),
    .l_next (rnd_l),
    .r_next (rnd_r)
  );

  // Final swap: the last round's halves enter IP^-1 as {R, L}.
  ip_inverse_permutation u_fp (
    .din  ({rnd_r, rnd_l}),
    .dout (fp_out)
  );

  assign last_round   = (cnt == CNT_W'(ROUNDS - 1));
  assign output_valid = (state == ST_DONE);
  assign input_ready  = (state == ST_READY) && !pause
                        && !restart_block && !rst;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    l_n      = l;
    r_n      = r;
    result_n = result;
    if (restart_block) begin
      state_n = ST_INIT;
      cnt_n   = '0;
    end else if (!pause) begin
      case (state)
        ST_INIT: begin
          if (start) state_n = ST_READY;
        end
        ST_READY: begin
          if (input_valid) begin
            l_n     = ip_out[BLOCK_W-1 -: HALF_W];
            r_n     = ip_out[HALF_W-1:0];
            cnt_n   = '0;
            state_n = ST_ROUND;
          end
        end
        ST_ROUND: begin
          l_n = rnd_l;
          r_n = rnd_r;
          if (last_round) begin
            result_n = fp_out;
            cnt_n    = '0;
            state_n  = ST_DONE;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        ST_DONE: begin
          if (output_ack) state_n = ST_READY;
        end
        default: state_n = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_INIT;
      cnt    <= '0;
      l      <= '0;
      r      <= '0;
      result <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      l      <= l_n;
      r      <= r_n;
      result <= result_n;
    end
  end

endmodule

// File: tb/tb_des_decryption_iterative.sv
// Bench for des_decryption_iterative: known-answer table plus
// pause / restart / reset / back-pressure sequences.
module tb_des_decryption_iterative;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         pause;
  logic         restart_block;
  logic         input_valid;
  logic         input_ready;
  logic [63:0]  ciphertext;
  logic [767:0] round_keys;
  logic         output_ack;
  logic         output_valid;
  logic [63:0]  result;

  always #5 clk = ~clk;

  des_decryption_iterative dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pause         (pause),
    .restart_block (restart_block),
    .input_valid   (input_valid),
    .input_ready   (input_ready),
    .ciphertext    (ciphertext),
    .round_keys    (round_keys),
    .output_ack    (output_ack),
    .output_valid  (output_valid),
    .result        (result)
  );

  typedef struct {
    logic [63:0] key;
    logic [63:0] ct;
    logic [63:0] pt;
  } vec_t;

  typedef struct {
    logic [63:0] pt;
    int          lat;
    int          edge_at;
  } exp_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  vec_t vecs [4];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   edge_no  = 0;

  always @(posedge clk) edge_no <= edge_no + 1;

  function automatic logic [767:0] key_sched(input logic [63:0] key);
    logic [55:0]  cd;
    logic [27:0]  c;
    logic [27:0]  d;
    logic [55:0]  cdk;
    logic [47:0]  sk;
    logic [767:0] rk;
    for (int i = 0; i < 56; i++) cd[6'(55-i)] = key[6'(64-PC1[i])];
    c  = cd[55:28];
    d  = cd[27:0];
    rk = '0;
    for (int k = 0; k < 16; k++) begin
      for (int s = 0; s < SH[k]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cdk = {c, d};
      for (int i = 0; i < 48; i++) sk[6'(47-i)] = cdk[6'(56-PC2[i])];
      rk[10'(767-48*k) -: 48] = sk;
    end
    return rk;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops the scoreboard on every rising output_valid.
  task automatic monitor();
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (output_valid === 1'b1 && !prev) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_valid: got 1, expected 0");
        end else begin
          e = sb.pop_front();
          check("result", result, e.pt);
          check("latency", 64'(edge_no - e.edge_at), 64'(e.lat));
        end
      end
      prev = (output_valid === 1'b1);
    end
  endtask

  task automatic accept(input int idx, input bit push, input int lat);
    bit   done;
    exp_t e;
    done        = 1'b0;
    ciphertext  = vecs[idx].ct;
    round_keys  = key_sched(vecs[idx].key);
    input_valid = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      #1;
      if (input_ready === 1'b1) begin
        tick();
        done = 1'b1;
        if (push) begin
          e.pt      = vecs[idx].pt;
          e.lat     = lat;
          e.edge_at = edge_no;
          sb.push_back(e);
        end
      end else begin
        tick();
      end
    end
    input_valid = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL accept_timeout: got ready 0, expected 1");
    end
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 60 && sb.size() != 0; t++) tick();
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL %s: got %0d pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic ack();
    output_ack = 1'b1;
    tick();
    output_ack = 1'b0;
    check("ready_after_ack", 64'(input_ready), 64'd1);
  endtask

  initial begin
    bit stable;
    vecs[0] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405,
                64'h0123456789ABCDEF};
    vecs[1] = '{64'h0E329232EA6D0D73, 64'h0000000000000000,
                64'h8787878787878787};
    vecs[2] = '{64'h0123456789ABCDEF, 64'h3FA40E8A984D4815,
                64'h4E6F772069732074};
    vecs[3] = '{64'h0101010101010101, 64'h8000000000000000,
                64'h95F8A5E5DD31D900};

    rst = 1'b1; start = 1'b0; pause = 1'b0; restart_block = 1'b0;
    input_valid = 1'b0; output_ack = 1'b0;
    ciphertext = '0; round_keys = '0;
    fork
      monitor();
    join_none

    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_valid", 64'(output_valid), 64'd0);
    check("rst_ready", 64'(input_ready), 64'd0);
    check("rst_result", result, 64'd0);

    // INIT ignores input_valid until start.
    input_valid = 1'b1;
    repeat (3) tick();
    check("init_ready", 64'(input_ready), 64'd0);
    input_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ready_after_start", 64'(input_ready), 64'd1);
    pause = 1'b1;
    #1;
    check("ready_paused", 64'(input_ready), 64'd0);
    pause = 1'b0;

    // Known-answer table.
    for (int i = 0; i < 4; i++) begin
      accept(i, 1'b1, 16);
      drain("drain_table");
      ack();
    end

    // Pause of 5 cycles while the counter sits at 7.
    accept(0, 1'b1, 21);
    repeat (7) tick();
    pause = 1'b1;
    input_valid = 1'b1;
    output_ack = 1'b1;
    for (int t = 0; t < 5; t++) begin
      check("pause_ready", 64'(input_ready), 64'd0);
      tick();
    end
    pause = 1'b0;
    input_valid = 1'b0;
    output_ack = 1'b0;
    drain("drain_pause");

    // DONE held without ack, then ack ignored while paused.
    stable = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (output_valid !== 1'b1 || result !== vecs[0].pt) stable = 1'b0;
    end
    check("done_hold", 64'(stable), 64'd1);
    input_valid = 1'b1;
    #1;
    check("done_no_accept", 64'(input_ready), 64'd0);
    input_valid = 1'b0;
    pause = 1'b1;
    output_ack = 1'b1;
    repeat (2) tick();
    check("ack_while_paused", 64'(output_valid), 64'd1);
    pause = 1'b0;
    tick();
    output_ack = 1'b0;
    check("ready_after_ack", 64'(input_ready), 64'd1);
    accept(1, 1'b1, 16);
    drain("drain_second");
    ack();

    // restart_block at counter 8, with pause also high.
    accept(2, 1'b0, 0);
    repeat (8) tick();
    restart_block = 1'b1;
    pause = 1'b1;
    tick();
    restart_block = 1'b0;
    pause = 1'b0;
    check("restart_valid", 64'(output_valid), 64'd0);
    check("restart_keeps_result", result, vecs[1].pt);
    input_valid = 1'b1;
    stable = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (input_ready !== 1'b0 || output_valid !== 1'b0) stable = 1'b0;
    end
    check("restart_init_idle", 64'(stable), 64'd1);
    input_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_start_ready", 64'(input_ready), 64'd1);

    // Reset mid-round abandons the block.
    accept(2, 1'b0, 0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("midrst_valid", 64'(output_valid), 64'd0);
    check("midrst_ready", 64'(input_ready), 64'd0);
    check("midrst_result", result, 64'd0);
    rst = 1'b0;
    repeat (20) tick();
    check("midrst_no_valid", 64'(output_valid), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    accept(3, 1'b1, 16);
    drain("drain_after_rst");
    check("final_result", result, vecs[3].pt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
